// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - control-path and RAM-side signals of the load/store sequencer
interface load_store_unit_if #(
  parameter int REGISTER_LENGTH = 32,
  parameter int ADDR_WIDTH      = 14
);
  logic                       request;
  logic                       write_request;
  logic                       privileged_mode;
  logic [REGISTER_LENGTH-1:0] address;
  logic [REGISTER_LENGTH-1:0] store_data;
  logic [REGISTER_LENGTH-1:0] mem_read_data;
  logic [ADDR_WIDTH-1:0]      mem_address;
  logic                       mem_write_enable;
  logic [REGISTER_LENGTH-1:0] mem_write_data;
  logic [REGISTER_LENGTH-1:0] load_data;
  logic                       bank_write;
  logic                       busy;
  logic                       done;
  logic                       fault;

  modport master (
    output request, write_request, privileged_mode, address, store_data, mem_read_data,
    input  mem_address, mem_write_enable, mem_write_data, load_data, bank_write, busy, done, fault
  );

  modport slave (
    input  request, write_request, privileged_mode, address, store_data, mem_read_data,
    output mem_address, mem_write_enable, mem_write_data, load_data, bank_write, busy, done, fault
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one-at-a-time load/store sequencer with user-mode code-area protection
module load_store_unit #(
  parameter int REGISTER_LENGTH = 32,
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_AREA_START = 8192,
  parameter int MEM_LATENCY     = 2
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, STORE, READ_WAIT, CAPTURE, DONE} state_e;

  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

  state_e                     state_q, state_d;
  logic [REGISTER_LENGTH-1:0] addr_q, addr_d;
  logic                       is_write_q, is_write_d;
  logic                       priv_q, priv_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0]      mem_address_q, mem_address_d;
  logic [REGISTER_LENGTH-1:0] mem_write_data_q, mem_write_data_d;
  logic [REGISTER_LENGTH-1:0] load_data_q, load_data_d;
  logic                       mem_write_enable_q, mem_write_enable_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       fault_q, fault_d;
  logic                       bank_write_q, bank_write_d;
  logic                       access_fault;

  // Out-of-range covers any set bit above the RAM word address; stores below
  // the data area are code-area writes and need privilege.
  assign access_fault = (|addr_q[REGISTER_LENGTH-1:ADDR_WIDTH]) ||
                        (is_write_q && !priv_q &&
                         (addr_q < REGISTER_LENGTH'(DATA_AREA_START)));

  // Outputs are registered, so each pulse is raised on the transition into its state.
  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    is_write_d         = is_write_q;
    priv_d             = priv_q;
    count_d            = count_q;
    mem_address_d      = mem_address_q;
    mem_write_data_d   = mem_write_data_q;
    load_data_d        = load_data_q;
    mem_write_enable_d = 1'b0;
    done_d             = 1'b0;
    fault_d            = 1'b0;
    bank_write_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.request) begin
          addr_d           = bus.address;
          is_write_d       = bus.write_request;
          priv_d           = bus.privileged_mode;
          mem_address_d    = bus.address[ADDR_WIDTH-1:0];
          mem_write_data_d = bus.store_data;
          state_d          = CHECK;
        end
      end
      CHECK: begin
        if (access_fault) begin
          state_d = DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if (is_write_q) begin
          state_d            = STORE;
          mem_write_enable_d = 1'b1;
        end else if (MEM_LATENCY == 1) begin
          state_d = CAPTURE;
        end else begin
          // The address is already on the RAM since CHECK, so the wait is one shorter.
          state_d = READ_WAIT;
          count_d = CNT_W'(MEM_LATENCY - 2);
        end
      end
      STORE: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      READ_WAIT: begin
        if (count_q == '0) state_d = CAPTURE;
        else               count_d = count_q - CNT_W'(1);
      end
      CAPTURE: begin
        load_data_d  = bus.mem_read_data;
        state_d      = DONE;
        done_d       = 1'b1;
        bank_write_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      is_write_q         <= 1'b0;
      priv_q             <= 1'b0;
      count_q            <= '0;
      mem_address_q      <= '0;
      mem_write_data_q   <= '0;
      load_data_q        <= '0;
      mem_write_enable_q <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      fault_q            <= 1'b0;
      bank_write_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      addr_q             <= addr_d;
      is_write_q         <= is_write_d;
      priv_q             <= priv_d;
      count_q            <= count_d;
      mem_address_q      <= mem_address_d;
      mem_write_data_q   <= mem_write_data_d;
      load_data_q        <= load_data_d;
      mem_write_enable_q <= mem_write_enable_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      fault_q            <= fault_d;
      bank_write_q       <= bank_write_d;
    end
  end

  assign bus.mem_address      = mem_address_q;
  assign bus.mem_write_data   = mem_write_data_q;
  assign bus.mem_write_enable = mem_write_enable_q;
  assign bus.load_data        = load_data_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.fault            = fault_q;
  assign bus.bank_write       = bank_write_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table, corner-case and randomized checks of load_store_unit
module tb_load_store_unit;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  load_store_unit_if #(.REGISTER_LENGTH(32), .ADDR_WIDTH(14)) bus ();

  load_store_unit #(
    .REGISTER_LENGTH(32), .ADDR_WIDTH(14), .DATA_AREA_START(8192), .MEM_LATENCY(L)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM: unwritten words hold a fixed pattern; reads take L cycles.
  bit   [31:0] ram    [16384];
  bit          ram_wr [16384];
  logic [31:0] rd_pipe[L];

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ram_word(input logic [13:0] a);
    return ram_wr[a] ? ram[a] : init_word(int'(a));
  endfunction

  always @(posedge clk) begin
    if (bus.mem_write_enable) begin
      ram[bus.mem_address]    <= bus.mem_write_data;
      ram_wr[bus.mem_address] <= 1'b1;
    end
    rd_pipe[0] <= ram_word(bus.mem_address);
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_read_data = rd_pipe[L-1];

  // Reference model: architectural memory image and last loaded value.
  logic [31:0] ref_mem [int];
  logic [31:0] ref_load = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(int'(a));
  endfunction

  function automatic bit ref_fault(input bit wr, input bit priv, input logic [31:0] a);
    return (a >= 32'h4000) || (wr && !priv && a < 32'd8192);
  endfunction

  task automatic model_update(input bit wr, input bit priv, input logic [31:0] a,
                              input logic [31:0] d);
    if (!ref_fault(wr, priv, a)) begin
      if (wr) ref_mem[int'(a)] = d;
      else    ref_load = ref_read(a);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after done.
  task automatic do_access(input bit wr, input bit priv, input logic [31:0] a,
                           input logic [31:0] d, input bit spur, input bit exp_fault,
                           input int exp_lat, input logic [31:0] exp_load);
    int done_cyc = 0, we_cnt = 0, bw_cnt = 0, bw_cyc = 0;
    bit we_bad = 0, busy_bad = 0, stray_fault = 0, fault_at = 0;
    logic [31:0] ld = '0;
    bus.request = 1'b1; bus.write_request = wr; bus.privileged_mode = priv;
    bus.address = a;    bus.store_data = d;
    @(posedge clk); #1;
    bus.request = 1'b0; bus.address = $urandom; bus.store_data = $urandom;
    bus.write_request = 1'($urandom); bus.privileged_mode = 1'b1;
    for (int cyc = 1; cyc <= 12 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_bad = 1;
      if (bus.mem_write_enable === 1'b1) begin
        we_cnt++;
        if (cyc != 2 || bus.mem_address !== a[13:0] || bus.mem_write_data !== d) we_bad = 1;
      end
      if (bus.bank_write === 1'b1) begin bw_cnt++; bw_cyc = cyc; end
      if (bus.fault === 1'b1 && bus.done !== 1'b1) stray_fault = 1;
      if (bus.done === 1'b1) begin
        done_cyc = cyc; fault_at = bus.fault; ld = bus.load_data;
      end else begin
        bus.request = spur && cyc <= 3;
      end
    end
    bus.request = 1'b0;
    if (done_cyc == 0) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(done_cyc), 32'(exp_lat));
    check("fault", 32'(fault_at), 32'(exp_fault));
    check("stray_fault", 32'(stray_fault), 32'd0);
    check("write_strobes", 32'(we_cnt), 32'(wr && !exp_fault));
    check("write_addr_data_timing", 32'(we_bad), 32'd0);
    check("bank_write_pulses", 32'(bw_cnt), 32'(!wr && !exp_fault));
    if (bw_cnt == 1) check("bank_write_cycle", 32'(bw_cyc), 32'(done_cyc));
    check("load_data", ld, exp_load);
    check("busy_during", 32'(busy_bad), 32'd0);
    @(negedge clk);
    check("busy_after", 32'({bus.busy, bus.done, bus.bank_write, bus.fault}), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({bus.busy, bus.done, bus.fault, bus.bank_write, bus.mem_write_enable}), 32'd0);
    check({name, "_regs"}, 32'(bus.mem_address) | bus.mem_write_data | bus.load_data, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    bit          priv;
    logic [31:0] addr;
    logic [31:0] data;
    bit          spur;
    bit          exp_fault;
    int          exp_lat;
    logic [31:0] exp_load;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 0, 32'd9000,    32'hDEADBEEF, 0, 0, 3, 32'h0};
    tbl[1]  = '{0, 0, 32'd9000,    32'h0,        1, 0, 4, 32'hDEADBEEF};
    tbl[2]  = '{1, 0, 32'd100,     32'h11112222, 0, 1, 2, 32'hDEADBEEF};
    tbl[3]  = '{0, 0, 32'd100,     32'h0,        0, 0, 4, init_word(100)};
    tbl[4]  = '{1, 1, 32'd100,     32'h33334444, 0, 0, 3, init_word(100)};
    tbl[5]  = '{0, 0, 32'd100,     32'h0,        0, 0, 4, 32'h33334444};
    tbl[6]  = '{0, 1, 32'h10000,   32'h0,        0, 1, 2, 32'h33334444};
    tbl[7]  = '{1, 0, 32'd8192,    32'hCAFEF00D, 0, 0, 3, 32'h33334444};
    tbl[8]  = '{1, 0, 32'd8191,    32'h55556666, 0, 1, 2, 32'h33334444};
    tbl[9]  = '{0, 0, 32'd8192,    32'h0,        1, 0, 4, 32'hCAFEF00D};
    tbl[10] = '{1, 1, 32'd16384,   32'h77778888, 0, 1, 2, 32'hCAFEF00D};
    tbl[11] = '{0, 1, 32'd8191,    32'h0,        0, 0, 4, init_word(8191)};
    tbl[12] = '{0, 1, 32'd0,       32'h0,        0, 0, 4, init_word(0)};
    tbl[13] = '{0, 0, 32'd9000,    32'h0,        0, 0, 4, 32'hDEADBEEF};

    bus.request = 1'b0; bus.write_request = 1'b0; bus.privileged_mode = 1'b0;
    bus.address = '0;   bus.store_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_access(tbl[i].wr, tbl[i].priv, tbl[i].addr, tbl[i].data, tbl[i].spur,
                tbl[i].exp_fault, tbl[i].exp_lat, tbl[i].exp_load);
      model_update(tbl[i].wr, tbl[i].priv, tbl[i].addr, tbl[i].data);
    end

    // Reset in cycle 3 of a load discards it entirely.
    begin
      int late = 0;
      bus.request = 1'b1; bus.write_request = 1'b0; bus.privileged_mode = 1'b0;
      bus.address = 32'd9000;
      @(posedge clk); #1 bus.request = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midop_reset");
      rst = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (bus.done || bus.bank_write || bus.mem_write_enable || bus.busy) late++;
      end
      check("midop_reset_no_later_activity", 32'(late), 32'd0);
      ref_load = '0;
    end
    do_access(1, 1, 32'd9100, 32'h0BADF00D, 0, 0, 3, 32'h0);
    model_update(1, 1, 32'd9100, 32'h0BADF00D);
    do_access(0, 0, 32'd9100, 32'h0, 0, 0, 4, 32'h0BADF00D);
    model_update(0, 0, 32'd9100, 32'h0);

    // Request together with reset is dropped.
    begin
      int act = 0;
      rst = 1'b1; bus.request = 1'b1; bus.write_request = 1'b1;
      bus.privileged_mode = 1'b1; bus.address = 32'd9200; bus.store_data = 32'h12345678;
      @(negedge clk);
      rst = 1'b0; bus.request = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (bus.busy || bus.done || bus.mem_write_enable) act++;
      end
      check("request_during_reset_dropped", 32'(act), 32'd0);
      check("request_during_reset_load_data", bus.load_data, 32'h0);
      ref_load = '0;
    end

    for (int n = 0; n < 60; n++) begin
      bit wr, priv, spur, f;
      logic [31:0] a, d;
      wr = 1'($urandom); priv = 1'($urandom); d = $urandom;
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 8191);
        1: a = $urandom_range(8192, 16383);
        2: a = 32'h4000 + $urandom_range(0, 32'h7FFF0000);
        default: case ($urandom_range(0, 3))
          0: a = 32'd100; 1: a = 32'd8192; 2: a = 32'd9000; default: a = 32'd16383;
        endcase
      endcase
      spur = !wr && 1'($urandom);
      f = ref_fault(wr, priv, a);
      do_access(wr, priv, a, d, spur, f, f ? 2 : (wr ? 3 : 2 + L),
                (!f && !wr) ? ref_read(a) : ref_load);
      model_update(wr, priv, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
